// File: rtl/imem_ctrl_pkg.sv
// imem_ctrl_pkg: shared sizes, masks and FSM encodings for the instruction
// memory controller.
//   WORD_SIZE  - address width in bits
//   BLOCK_SIZE - one memory block (16 bytes) in bits
//   BYTE_SIZE  - bits per byte
//   LINE_MASK  - clears the low 7 address bits to form the fetch line address
package imem_ctrl_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int BLOCK_SIZE = 128;
    localparam int BYTE_SIZE  = 8;

    localparam logic [WORD_SIZE-1:0] LINE_MASK = ~32'd127;

    // Arbiter pointer values: which requester was granted last.
    localparam logic LAST_FETCH = 1'b0;
    localparam logic LAST_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_ISSUE = 3'd1,
        ST_RD_WAIT  = 3'd2,
        ST_WR_ISSUE = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

endpackage

// File: rtl/imem_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   req[0] = fetch, req[1] = write
//   en     - arbitration allowed this cycle (controller idle)
//   gnt    - one-hot grant, combinational from req/en/last
//   last   - requester granted most recently (LAST_FETCH / LAST_WRITE)
module rr_arb2
    import imem_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    output logic       last
);

    logic last_q, last_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Tie: hand the grant to whoever did not win last time.
                2'b11:   gnt = (last_q == LAST_WRITE) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
        last_d = last_q;
        if (gnt != 2'b00) last_d = gnt[1];
    end

    // Reset to "write" so a fetch wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= LAST_WRITE;
        else        last_q <= last_d;
    end

    assign last = last_q;

endmodule

// File: rtl/imem_ctrl.sv
// imem_ctrl: owns the single instruction-memory port. Arbitrates a two-block
// fetch refill against a one-block write, strobes the memory and waits out
// its registered read latency before returning data.
//   f_req/f_addr -> f_ack/f_data/f_line : fetch requester
//   w_req/w_addr/w_data -> w_ack        : write requester
//   mem_addr/mem_readable/mem_writable/mem_write, mem_out1/mem_out2 : memory
//   busy : controller not idle
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1   // 1..7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    f_req,
    input  logic [WORD_SIZE-1:0]    f_addr,
    output logic                    f_ack,
    output logic [2*BLOCK_SIZE-1:0] f_data,
    output logic [WORD_SIZE-1:0]    f_line,
    input  logic                    w_req,
    input  logic [WORD_SIZE-1:0]    w_addr,
    input  logic [BLOCK_SIZE-1:0]   w_data,
    output logic                    w_ack,
    output logic [WORD_SIZE-1:0]    mem_addr,
    output logic                    mem_readable,
    output logic                    mem_writable,
    output logic [BLOCK_SIZE-1:0]   mem_write,
    input  logic [BLOCK_SIZE-1:0]   mem_out1,
    input  logic [BLOCK_SIZE-1:0]   mem_out2,
    output logic                    busy
);

    localparam logic [2:0] LAT_LAST = 3'(MEM_LAT - 1);

    state_e                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic                    f_ack_q, f_ack_d;
    logic                    w_ack_q, w_ack_d;
    logic [2*BLOCK_SIZE-1:0] f_data_q, f_data_d;
    logic [WORD_SIZE-1:0]    f_line_q, f_line_d;
    logic [WORD_SIZE-1:0]    mem_addr_q, mem_addr_d;
    logic [BLOCK_SIZE-1:0]   mem_write_q, mem_write_d;

    logic [1:0] gnt;
    logic       arb_last;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_IDLE),
        .req   ({w_req, f_req}),
        .gnt   (gnt),
        .last  (arb_last)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f_ack_d     = 1'b0;
        w_ack_d     = 1'b0;
        f_data_d    = f_data_q;
        f_line_d    = f_line_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt[0]) begin
                    mem_addr_d = f_addr;
                    state_d    = ST_RD_ISSUE;
                end else if (gnt[1]) begin
                    mem_addr_d  = w_addr;
                    mem_write_d = w_data;
                    state_d     = ST_WR_ISSUE;
                end
            end
            ST_RD_ISSUE: begin
                cnt_d   = 3'd0;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                // The memory output moved on the strobe edge; sample it only
                // after MEM_LAT full wait cycles.
                if (cnt_q == LAT_LAST) begin
                    cnt_d    = 3'd0;
                    f_data_d = {mem_out1, mem_out2};
                    f_line_d = mem_addr_q & LINE_MASK;
                    f_ack_d  = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ST_WR_ISSUE: begin
                w_ack_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            f_ack_q     <= 1'b0;
            w_ack_q     <= 1'b0;
            f_data_q    <= '0;
            f_line_q    <= '0;
            mem_addr_q  <= '0;
            mem_write_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f_ack_q     <= f_ack_d;
            w_ack_q     <= w_ack_d;
            f_data_q    <= f_data_d;
            f_line_q    <= f_line_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
        end
    end

    // Strobes decode straight from state so an async reset kills them at once.
    assign mem_readable = (state_q == ST_RD_ISSUE);
    assign mem_writable = (state_q == ST_WR_ISSUE);
    assign busy         = (state_q != ST_IDLE);

    assign f_ack     = f_ack_q;
    assign w_ack     = w_ack_q;
    assign f_data    = f_data_q;
    assign f_line    = f_line_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_imem_ctrl.sv
// tb_imem_ctrl: directed checks of imem_ctrl with MEM_LAT=1 (u_dut) and
// MEM_LAT=4 (u_dut4) against a byte-array memory model.
module tb_imem_ctrl;
    import imem_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                    f_req = 1'b0, w_req = 1'b0;
    logic [WORD_SIZE-1:0]    f_addr = '0, w_addr = '0;
    logic [BLOCK_SIZE-1:0]   w_data = '0;
    logic                    f_ack, w_ack, mem_readable, mem_writable, busy;
    logic [2*BLOCK_SIZE-1:0] f_data;
    logic [WORD_SIZE-1:0]    f_line, mem_addr;
    logic [BLOCK_SIZE-1:0]   mem_write;
    logic [BLOCK_SIZE-1:0]   mem_out1 = '0, mem_out2 = '0;

    logic                    f_req4 = 1'b0;
    logic [WORD_SIZE-1:0]    f_addr4 = '0;
    logic                    f_ack4, w_ack4, mem_readable4, mem_writable4, busy4;
    logic [2*BLOCK_SIZE-1:0] f_data4;
    logic [WORD_SIZE-1:0]    f_line4, mem_addr4;
    logic [BLOCK_SIZE-1:0]   mem_write4;
    logic [BLOCK_SIZE-1:0]   mem_out1_4 = '0, mem_out2_4 = '0;

    logic [7:0] mem [0:511];

    int compared = 0;
    int mismatched = 0;

    logic [2*BLOCK_SIZE-1:0] exp_line80;
    logic [BLOCK_SIZE-1:0]   exp_w;
    logic [BLOCK_SIZE-1:0]   exp_hi10;

    imem_ctrl #(.MEM_LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data), .f_line(f_line),
        .w_req(w_req), .w_addr(w_addr), .w_data(w_data), .w_ack(w_ack),
        .mem_addr(mem_addr), .mem_readable(mem_readable), .mem_writable(mem_writable),
        .mem_write(mem_write), .mem_out1(mem_out1), .mem_out2(mem_out2), .busy(busy)
    );

    imem_ctrl #(.MEM_LAT(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .f_req(f_req4), .f_addr(f_addr4), .f_ack(f_ack4), .f_data(f_data4), .f_line(f_line4),
        .w_req(1'b0), .w_addr(32'd0), .w_data(128'd0), .w_ack(w_ack4),
        .mem_addr(mem_addr4), .mem_readable(mem_readable4), .mem_writable(mem_writable4),
        .mem_write(mem_write4), .mem_out1(mem_out1_4), .mem_out2(mem_out2_4), .busy(busy4)
    );

    function automatic logic [BLOCK_SIZE-1:0] rd_blk(input int base);
        logic [BLOCK_SIZE-1:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) r = {r[BLOCK_SIZE-9:0], mem[(base + k) % 512]};
        return r;
    endfunction

    // Memory model: registered outputs updated with blocking assigns on the
    // strobe edge; ignores the low 7 address bits.
    always @(posedge clk) begin
        if (mem_writable)
            for (int k = 0; k < 16; k++)
                mem[{mem_addr[8:7], 7'd0} + k] = mem_write[BLOCK_SIZE-1-8*k -: 8];
        if (mem_readable) begin
            mem_out1 = rd_blk({23'd0, mem_addr[8:7], 7'd0});
            mem_out2 = rd_blk({23'd0, mem_addr[8:7], 7'd0} + 16);
        end
    end

    always @(posedge clk) begin
        if (mem_readable4) begin
            mem_out1_4 = rd_blk({23'd0, mem_addr4[8:7], 7'd0});
            mem_out2_4 = rd_blk({23'd0, mem_addr4[8:7], 7'd0} + 16);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy got %0b want 0", busy); end
        compared++; if ({f_ack, w_ack} !== 2'b00) begin mismatched++; $display("FAIL reset_acks got %b want 00", {f_ack, w_ack}); end
        compared++; if ({mem_readable, mem_writable} !== 2'b00) begin mismatched++; $display("FAIL reset_strobes got %b want 00", {mem_readable, mem_writable}); end
        compared++; if (f_data !== '0) begin mismatched++; $display("FAIL reset_f_data got %h want 0", f_data); end
        compared++; if (f_line !== '0 || mem_addr !== '0) begin mismatched++; $display("FAIL reset_addr got f_line %h mem_addr %h want 0", f_line, mem_addr); end
        compared++; if (mem_write !== '0) begin mismatched++; $display("FAIL reset_mem_write got %h want 0", mem_write); end
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        f_addr = 32'h85; f_req = 1'b1;                       // cycle 0
        tick();                                              // cycle 1
        compared++; if (mem_readable !== 1'b1 || mem_writable !== 1'b0) begin mismatched++; $display("FAIL fetch_c1_strobe got rd %0b wr %0b want 1 0", mem_readable, mem_writable); end
        compared++; if (mem_addr !== 32'h85) begin mismatched++; $display("FAIL fetch_mem_addr got %h want 85", mem_addr); end
        tick();                                              // cycle 2
        compared++; if (mem_readable !== 1'b0 || busy !== 1'b1 || f_ack !== 1'b0) begin mismatched++; $display("FAIL fetch_c2 got rd %0b busy %0b ack %0b want 0 1 0", mem_readable, busy, f_ack); end
        tick();                                              // cycle 3
        compared++; if (f_ack !== 1'b1) begin mismatched++; $display("FAIL fetch_ack_c3 got %0b want 1", f_ack); end
        compared++; if (f_line !== 32'h80) begin mismatched++; $display("FAIL fetch_f_line got %h want 80", f_line); end
        compared++; if (f_data !== exp_line80) begin mismatched++; $display("FAIL fetch_f_data got %h want %h", f_data, exp_line80); end
        f_req = 1'b0;
        tick();                                              // cycle 4
        compared++; if (f_ack !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL fetch_c4_idle got ack %0b busy %0b want 0 0", f_ack, busy); end
    endtask

    task automatic test_write_readback();
        w_addr = 32'h100; w_data = exp_w; w_req = 1'b1;      // cycle 0
        tick();                                              // cycle 1
        compared++; if (mem_writable !== 1'b1 || mem_readable !== 1'b0) begin mismatched++; $display("FAIL wr_c1_strobe got wr %0b rd %0b want 1 0", mem_writable, mem_readable); end
        compared++; if (mem_write !== exp_w || mem_addr !== 32'h100) begin mismatched++; $display("FAIL wr_c1_data got %h @%h want %h @100", mem_write, mem_addr, exp_w); end
        tick();                                              // cycle 2
        compared++; if (w_ack !== 1'b1 || mem_writable !== 1'b0) begin mismatched++; $display("FAIL wr_ack_c2 got ack %0b wr %0b want 1 0", w_ack, mem_writable); end
        w_req = 1'b0;
        tick();                                              // cycle 3
        compared++; if (busy !== 1'b0 || w_ack !== 1'b0) begin mismatched++; $display("FAIL wr_c3_idle got busy %0b ack %0b want 0 0", busy, w_ack); end
        f_addr = 32'h100; f_req = 1'b1;
        repeat (3) tick();
        compared++; if (f_ack !== 1'b1 || f_data !== {exp_w, exp_hi10}) begin mismatched++; $display("FAIL wr_readback got ack %0b data %h want 1 %h", f_ack, f_data, {exp_w, exp_hi10}); end
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        int last_cyc;
        logic last_was_w;
        n = 0; last_cyc = 0; last_was_w = 1'b0;
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
        f_addr = 32'h80; w_addr = 32'h100; w_data = exp_w;
        f_req = 1'b1; w_req = 1'b1;
        for (int cyc = 1; cyc <= 100 && n < 10; cyc++) begin
            tick();
            compared++; if (f_ack && w_ack) begin mismatched++; $display("FAIL b2b_two_acks cycle %0d got both want one", cyc); end
            compared++; if (mem_readable && mem_writable) begin mismatched++; $display("FAIL b2b_strobes cycle %0d got both want exclusive", cyc); end
            if (f_ack || w_ack) begin
                compared++; if (w_ack !== n[0]) begin mismatched++; $display("FAIL b2b_order grant %0d got %s want %s", n, w_ack ? "write" : "fetch", n[0] ? "write" : "fetch"); end
                if (n > 0) begin
                    // fetch ack -> write ack takes 3 cycles; write ack -> fetch ack takes 3+MEM_LAT
                    compared++; if ((cyc - last_cyc) != (last_was_w ? 4 : 3)) begin mismatched++; $display("FAIL b2b_gap grant %0d got %0d want %0d", n, cyc - last_cyc, last_was_w ? 4 : 3); end
                end
                last_cyc = cyc; last_was_w = w_ack; n++;
            end
        end
        compared++; if (n != 10) begin mismatched++; $display("FAIL b2b_timeout got %0d grants want 10", n); end
        f_req = 1'b0; w_req = 1'b0;
        repeat (2) tick();
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL b2b_idle got busy %0b want 0", busy); end
    endtask

    task automatic test_lat4();
        f_addr4 = 32'h85; f_req4 = 1'b1;                     // cycle 0
        for (int c = 1; c <= 5; c++) begin
            tick();
            compared++; if (f_ack4 !== 1'b0 || f_data4 !== '0) begin mismatched++; $display("FAIL lat4_hold cycle %0d got ack %0b data %h want 0 0", c, f_ack4, f_data4); end
            if (c == 1) begin
                compared++; if (mem_readable4 !== 1'b1) begin mismatched++; $display("FAIL lat4_strobe got %0b want 1", mem_readable4); end
            end
        end
        tick();                                              // cycle 6
        compared++; if (f_ack4 !== 1'b1 || f_data4 !== exp_line80) begin mismatched++; $display("FAIL lat4_ack_c6 got ack %0b data %h want 1 %h", f_ack4, f_data4, exp_line80); end
        f_req4 = 1'b0;
        tick();
    endtask

    task automatic test_reset_rdwait();
        int acks;
        acks = 0;
        f_addr = 32'h100; f_req = 1'b1;
        tick(); tick();                                      // cycle 2: RD_WAIT
        #2 rst_n = 1'b0;
        #1;
        compared++; if (busy !== 1'b0 || mem_readable !== 1'b0 || f_ack !== 1'b0) begin mismatched++; $display("FAIL rst_rd_ctrl got busy %0b rd %0b ack %0b want 0 0 0", busy, mem_readable, f_ack); end
        compared++; if (f_data !== '0 || f_line !== '0 || mem_addr !== '0) begin mismatched++; $display("FAIL rst_rd_data got %h %h %h want 0", f_data, f_line, mem_addr); end
        f_req = 1'b0;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (f_ack) acks++;
        end
        compared++; if (acks != 0) begin mismatched++; $display("FAIL rst_rd_no_ack got %0d acks want 0", acks); end
        f_addr = 32'h85; f_req = 1'b1;
        tick();
        compared++; if (mem_readable !== 1'b1) begin mismatched++; $display("FAIL rst_rd_regrant got rd %0b want 1", mem_readable); end
        tick(); tick();
        compared++; if (f_ack !== 1'b1 || f_data !== exp_line80) begin mismatched++; $display("FAIL rst_rd_refetch got ack %0b data %h want 1 %h", f_ack, f_data, exp_line80); end
        f_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_wrissue();
        int acks;
        logic [BLOCK_SIZE-1:0] exp_180;
        acks = 0;
        exp_180 = '0;
        for (int i = 0; i < 16; i++) exp_180 = {exp_180[BLOCK_SIZE-9:0], 8'(8'h80 + i)};
        w_addr = 32'h180; w_data = {16{8'hA5}}; w_req = 1'b1;
        tick();                                              // cycle 1: WR_ISSUE
        compared++; if (mem_writable !== 1'b1) begin mismatched++; $display("FAIL rst_wr_strobe got %0b want 1", mem_writable); end
        #2 rst_n = 1'b0;
        #1;
        compared++; if (mem_writable !== 1'b0 || mem_write !== '0) begin mismatched++; $display("FAIL rst_wr_outputs got wr %0b data %h want 0 0", mem_writable, mem_write); end
        w_req = 1'b0;
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (w_ack) acks++;
        end
        compared++; if (acks != 0) begin mismatched++; $display("FAIL rst_wr_no_ack got %0d acks want 0", acks); end
        compared++; if (rd_blk(32'h180) !== exp_180) begin mismatched++; $display("FAIL rst_wr_mem got %h want %h", rd_blk(32'h180), exp_180); end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i);
        exp_line80 = '0;
        for (int i = 0; i < 32; i++) exp_line80 = {exp_line80[2*BLOCK_SIZE-9:0], 8'(8'h80 + i)};
        exp_w = '0;
        for (int i = 0; i < 16; i++) exp_w = {exp_w[BLOCK_SIZE-9:0], 8'(15 - i)};
        exp_hi10 = '0;
        for (int i = 0; i < 16; i++) exp_hi10 = {exp_hi10[BLOCK_SIZE-9:0], 8'(8'h10 + i)};

        test_reset();
        test_fetch();
        test_write_readback();
        test_back_to_back();
        test_lat4();
        test_reset_rdwait();
        test_reset_wrissue();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Sequencer and two-way arbiter that owns the single port of the instruction memory. It serves an instruction-fetch refill requester (two-block read) and a write requester (one-block program load or self-modifying store). It drives the memory's `readable`/`writable` strobes and waits out the memory's registered read latency before returning data. It sits between the fetch stage and the instruction memory; it does no caching.

## Interface
- `MEM_LAT`, default 1: wait cycles after the read-strobe cycle before capture; legal range 1..7.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `f_req`  in  1  fetch request; held with `f_addr` until `f_ack`.
- `f_addr`  in  `WORD_SIZE`  fetch byte address.
- `f_ack`  out  1  one-cycle pulse; `f_data` and `f_line` valid in this cycle.
- `f_data`  out  2*`BLOCK_SIZE`  {first block, second block}; holds until the next fetch capture.
- `f_line`  out  `WORD_SIZE`  `f_addr` with its low 7 bits cleared.
- `w_req`  in  1  write request; held with `w_addr` and `w_data` until `w_ack`.
- `w_addr`  in  `WORD_SIZE`  write byte address.
- `w_data`  in  `BLOCK_SIZE`  block to write, most significant byte first.
- `w_ack`  out  1  one-cycle pulse; the write has been committed.
- `mem_addr`  out  `WORD_SIZE`  memory address, the latched request address.
- `mem_readable`  out  1  read strobe.
- `mem_writable`  out  1  write strobe.
- `mem_write`  out  `BLOCK_SIZE`  write data.
- `mem_out1`, `mem_out2`  in  `BLOCK_SIZE`  registered memory read outputs.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States:
  - IDLE
  - RD_ISSUE
  - RD_WAIT
  - WR_ISSUE
  - DONE
- IDLE: arbitrate among the pending requests.
  - If a grant is made, latch the address (and data for a write) in the same edge.
  - A fetch grant goes to RD_ISSUE; a write grant goes to WR_ISSUE.
- Arbitration is round-robin using a `last` pointer.
  - Only one request pending: grant it.
  - Both pending: grant the one not equal to `last`.
  - `last` updates on every grant.
- RD_ISSUE: `mem_readable`=1 for exactly one cycle, then go to RD_WAIT.
- RD_WAIT: lasts `MEM_LAT` cycles, counted by a 3-bit counter.
  - On the exit edge, capture `f_data`={`mem_out1`,`mem_out2`} and compute `f_line`.
  - Then go to DONE.
  - Capture is never on the strobe edge itself, because the memory updates its outputs with blocking assigns.
- WR_ISSUE: `mem_writable`=1 and `mem_write`=latched data for exactly one cycle, then go to DONE.
- DONE: pulse `f_ack` or `w_ack` according to the operation; no arbitration; return to IDLE.
  - A requester still holding req in IDLE is treated as a new request.
- `mem_readable` and `mem_writable` are never high together, and never high outside RD_ISSUE/WR_ISSUE.
- Address is passed through unmodified; the memory ignores the low 7 bits.
- Reset, whether at power-on or mid-operation, forces:
  - state=IDLE, counter=0;
  - all strobes, acks and `busy`=0;
  - `f_data`, `f_line`, `mem_addr`, `mem_write`=0;
  - `last`=write, so fetch wins the first tie.
- An aborted write never reaches the memory unless its WR_ISSUE edge has already occurred.

## Timing
- Fetch, with req sampled in IDLE in cycle 0:
  - `mem_readable` high in cycle 1;
  - RD_WAIT in cycles 2..1+`MEM_LAT`;
  - `f_ack` high in cycle 2+`MEM_LAT`;
  - IDLE in cycle 3+`MEM_LAT`.
- Write, with req sampled in cycle 0: `mem_writable` high in cycle 1, `w_ack` in cycle 2, IDLE in cycle 3.
- Back-to-back throughput:
  - fetch: one every 3+`MEM_LAT` cycles;
  - write: one every 3 cycles.
- All outputs are registered except `mem_readable`, `mem_writable` and `busy`, which are decoded from the state register only.

## Structure
- State encodings (3-bit) and `LINE_MASK` (~127) go as `define` constants in define.v, alongside `WORD_SIZE`, `BLOCK_SIZE` and `BYTE_SIZE`.
- Sub-module `rr_arb2`: 2-way round-robin arbiter.
  - Inputs: req[1:0], `en`, `clk`, `rst_n`.
  - Outputs: one-hot `gnt` and the internal `last` pointer.
- `imem_ctrl` holds the FSM, wait counter and data latches.

## Test plan
- Single fetch, `MEM_LAT`=1, memory preloaded with bytes 0x00..0xFF:
  - `f_addr`=0x85 → `mem_readable` in cycle 1 only;
  - `f_ack` in cycle 3;
  - `f_line`=0x80;
  - `f_data`=bytes 0x80..0x9F, MSB first.
- Write then read-back: `w_addr`=0x100, `w_data`=0x0F0E…00 → `w_ack` in cycle 2; a following fetch of 0x100 returns that block as the upper 128 bits.
- Both requests held continuously for 10 grants → grant order fetch, write, fetch, write…; never two acks in one cycle; strobes mutually exclusive.
- `MEM_LAT`=4 fetch → `f_ack` in cycle 6; `f_data` unchanged from its prior value until that edge.
- Reset asserted asynchronously in RD_WAIT → all outputs 0 immediately; no `f_ack`; the first request after release is granted normally.
- Reset asserted during WR_ISSUE before the edge → memory contents at `w_addr` unchanged; no `w_ack`.
